// File: rtl/lsu_stage_pkg.sv
// Shared types and helpers for the load/store writeback stage.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2
    } lsu_state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Byte-enable pattern for an access of the given size at lane 0.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Natural alignment: an access must not straddle its own size boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_stage_if.sv
// Data-memory request/response port shared by the LSU and the memory side.
interface lsu_stage_if #(
    parameter int XLEN = 64
);
    logic            dmem_req_valid;
    logic            dmem_req_ready;
    logic            dmem_req_we;
    logic [XLEN-1:0] dmem_req_addr;
    logic [XLEN-1:0] dmem_req_wdata;
    logic [7:0]      dmem_req_wstrb;
    logic            dmem_resp_valid;
    logic [XLEN-1:0] dmem_resp_rdata;

    modport master (
        output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
        output dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
    );
endinterface

// File: rtl/lsu_stage_load_align.sv
// Picks the addressed lane out of a doubleword and extends it to XLEN.
module load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      offset,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] data
);
    logic [XLEN-1:0] lane;

    assign lane = rdata >> {offset, 3'b000};

    // Sign- or zero-extend the low bytes of the shifted lane.
    always_comb begin
        data = lane;
        case (size)
            SZ_B: data = {{(XLEN-8){lane[7] & ~is_unsigned}}, lane[7:0]};
            SZ_H: data = {{(XLEN-16){lane[15] & ~is_unsigned}}, lane[15:0]};
            SZ_W: data = {{(XLEN-32){lane[31] & ~is_unsigned}}, lane[31:0]};
            default: data = lane;
        endcase
    end
endmodule

// File: rtl/lsu_stage.sv
// Memory/writeback stage: passes ALU results through, runs loads and stores
// on the D-memory port and stalls upstream while an access is outstanding.
module lsu_stage
    import lsu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int REGW = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [XLEN-1:0]  in_data,
    input  logic [XLEN-1:0]  in_mem_addr,
    input  logic             in_store,
    input  logic             in_load,
    input  logic [1:0]       in_size,
    input  logic             in_unsigned,
    input  logic [REGW-1:0]  in_reg_dest,
    input  logic [31:0]      in_pc,
    input  logic             is_flush,
    output logic             lsu_busy,
    lsu_stage_if.master      dmem,
    output logic             wb_en,
    output logic [REGW-1:0]  wb_reg,
    output logic [XLEN-1:0]  wb_data,
    output logic [31:0]      wb_pc,
    output logic             misaligned
);
    lsu_state_t      state_reg, state_next;
    logic [XLEN-1:0] acc_addr;
    logic            is_mem, mis, accept, start_mem, req_fire, resp_fire;
    logic            drop_reg;
    logic [2:0]      off_reg;
    logic [1:0]      size_reg;
    logic            uns_reg;
    logic [REGW-1:0] dest_reg;
    logic [31:0]     pc_reg;
    logic [XLEN-1:0] load_data;
    logic            req_valid_reg, req_we_reg;
    logic [XLEN-1:0] req_addr_reg, req_wdata_reg;
    logic [7:0]      req_wstrb_reg;

    // Stores take their address from the separate store-address field.
    assign is_mem    = in_load | in_store;
    assign acc_addr  = in_store ? in_mem_addr : in_data;
    assign mis       = is_misaligned(in_size, acc_addr[2:0]);
    assign accept    = in_valid && (state_reg == IDLE) && !is_flush;
    assign start_mem = accept && is_mem && !mis;
    assign req_fire  = (state_reg == REQ) && req_valid_reg && dmem.dmem_req_ready;
    assign resp_fire = (state_reg == WAIT_RESP) && dmem.dmem_resp_valid;
    assign lsu_busy  = (state_reg != IDLE);

    assign dmem.dmem_req_valid = req_valid_reg;
    assign dmem.dmem_req_we    = req_we_reg;
    assign dmem.dmem_req_addr  = req_addr_reg;
    assign dmem.dmem_req_wdata = req_wdata_reg;
    assign dmem.dmem_req_wstrb = req_wstrb_reg;

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata       (dmem.dmem_resp_rdata),
        .offset      (off_reg),
        .size        (size_reg),
        .is_unsigned (uns_reg),
        .data        (load_data)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next state: stores are posted, loads wait for their in-order response.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (start_mem) state_next = REQ;
            REQ:       if (req_fire)  state_next = req_we_reg ? IDLE : WAIT_RESP;
            WAIT_RESP: if (resp_fire) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Request, writeback and drop-flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_valid_reg <= 1'b0;
            req_we_reg    <= 1'b0;
            req_addr_reg  <= '0;
            req_wdata_reg <= '0;
            req_wstrb_reg <= '0;
            off_reg       <= '0;
            size_reg      <= '0;
            uns_reg       <= 1'b0;
            dest_reg      <= '0;
            pc_reg        <= '0;
            drop_reg      <= 1'b0;
            wb_en         <= 1'b0;
            wb_reg        <= '0;
            wb_data       <= '0;
            wb_pc         <= '0;
            misaligned    <= 1'b0;
        end else begin
            wb_en      <= 1'b0;
            misaligned <= 1'b0;
            if (accept) begin
                if (!is_mem) begin
                    wb_en   <= (in_reg_dest != '0);
                    wb_reg  <= in_reg_dest;
                    wb_data <= in_data;
                    wb_pc   <= in_pc;
                end else if (mis) begin
                    misaligned <= 1'b1;
                end else begin
                    req_valid_reg <= 1'b1;
                    req_we_reg    <= in_store;
                    req_addr_reg  <= {acc_addr[XLEN-1:3], 3'b000};
                    req_wdata_reg <= in_store ? (in_data << {acc_addr[2:0], 3'b000}) : '0;
                    req_wstrb_reg <= in_store ? (size_mask(in_size) << acc_addr[2:0]) : 8'h00;
                    off_reg       <= acc_addr[2:0];
                    size_reg      <= in_size;
                    uns_reg       <= in_unsigned;
                    dest_reg      <= in_reg_dest;
                    pc_reg        <= in_pc;
                end
            end
            if (req_fire) req_valid_reg <= 1'b0;
            if (resp_fire && !drop_reg && !is_flush) begin
                wb_en   <= (dest_reg != '0);
                wb_reg  <= dest_reg;
                wb_data <= load_data;
                wb_pc   <= pc_reg;
            end
            // A flushed access still finishes on the bus but never writes back.
            if (state_reg != IDLE) begin
                if (state_next == IDLE) drop_reg <= 1'b0;
                else if (is_flush)      drop_reg <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage with a writeback/request scoreboard.
module tb_lsu_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_store, in_load, in_unsigned, is_flush;
    logic [63:0] in_data, in_mem_addr;
    logic [1:0]  in_size;
    logic [4:0]  in_reg_dest;
    logic [31:0] in_pc;
    logic        lsu_busy, wb_en, misaligned;
    logic [4:0]  wb_reg;
    logic [63:0] wb_data;
    logic [31:0] wb_pc;

    lsu_stage_if #(.XLEN(64)) dm ();

    lsu_stage #(.XLEN(64), .REGW(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_mem_addr(in_mem_addr), .in_store(in_store), .in_load(in_load),
        .in_size(in_size), .in_unsigned(in_unsigned), .in_reg_dest(in_reg_dest),
        .in_pc(in_pc), .is_flush(is_flush), .lsu_busy(lsu_busy), .dmem(dm),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .wb_pc(wb_pc),
        .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r;
        logic [63:0] d;
        logic [31:0] pc;
    } wb_t;

    wb_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          req_exp_valid = 1'b0;
    logic        req_e_we;
    logic [63:0] req_e_addr, req_e_wdata;
    logic [7:0]  req_e_wstrb;
    int          req_cycles = 0;
    logic [63:0] obs_addr, obs_wdata;
    logic [7:0]  obs_wstrb;
    int          mis_expected = 0;
    int          mis_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference load result from the architectural rule: lane at the byte
    // offset, truncated to the access size, then sign- or zero-extended.
    function automatic logic [63:0] exp_load(input logic [63:0] rdata, input logic [63:0] addr,
                                             input int size, input bit uns);
        int          nbits;
        logic [63:0] v;
        logic [63:0] m;
        nbits = 8 * (1 << size);
        v = rdata >> (8 * int'(addr[2:0]));
        if (nbits < 64) begin
            m = (64'd1 << nbits) - 64'd1;
            v = v & m;
            if (!uns && v[nbits-1]) v = v | ~m;
        end
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alu(input logic [63:0] data, input logic [4:0] dest, input logic [31:0] pc);
        in_valid = 1; in_load = 0; in_store = 0; in_data = data; in_reg_dest = dest; in_pc = pc;
        if (dest != 0) exp_q.push_back('{dest, data, pc});
        cyc();
        in_valid = 0;
        chk("alu_wb_en", wb_en, (dest != 0));
        chk("alu_busy", lsu_busy, 0);
    endtask

    task automatic do_store(input logic [63:0] data, input logic [63:0] addr, input int size,
                            input int rdelay);
        in_valid = 1; in_store = 1; in_load = 0; in_data = data; in_mem_addr = addr;
        in_size = size[1:0]; in_reg_dest = 5'd3; in_pc = 32'h500;
        req_e_we = 1; req_e_addr = addr & ~64'h7;
        req_e_wstrb = 8'(((1 << (1 << size)) - 1) << int'(addr[2:0]));
        req_e_wdata = data << (8 * int'(addr[2:0]));
        req_exp_valid = 1; req_cycles = 0;
        cyc();
        in_valid = 0; in_store = 0;
        chk("st_busy", lsu_busy, 1);
        repeat (rdelay) cyc();
        dm.dmem_req_ready = 1;
        cyc();
        dm.dmem_req_ready = 0; req_exp_valid = 0;
        chk("st_req_dropped", dm.dmem_req_valid, 0);
        chk("st_busy_done", lsu_busy, 0);
        chk("st_wb_en", wb_en, 0);
    endtask

    // fmode: 0 normal, 1 flush while waiting for the response,
    // 2 flush on the response cycle, 3 flush while the request is pending.
    task automatic do_load(input logic [63:0] addr, input int size, input bit uns,
                           input logic [4:0] dest, input logic [31:0] pc, input int rdelay,
                           input int sdelay, input logic [63:0] rdata, input int fmode);
        bit wb;
        wb = (dest != 0) && (fmode == 0);
        in_valid = 1; in_load = 1; in_store = 0; in_data = addr; in_mem_addr = 64'hAAAA_5555_AAAA_5555;
        in_size = size[1:0]; in_unsigned = uns; in_reg_dest = dest; in_pc = pc;
        req_e_we = 0; req_e_addr = addr & ~64'h7; req_e_wdata = 0; req_e_wstrb = 0;
        req_exp_valid = 1; req_cycles = 0;
        if (wb) exp_q.push_back('{dest, exp_load(rdata, addr, size, uns), pc});
        cyc();
        in_valid = 0; in_load = 0;
        chk("ld_busy", lsu_busy, 1);
        for (int i = 0; i < rdelay; i++) begin
            if (fmode == 3 && i == 0) is_flush = 1;
            cyc();
            is_flush = 0;
        end
        dm.dmem_req_ready = 1;
        cyc();
        dm.dmem_req_ready = 0; req_exp_valid = 0;
        chk("ld_req_dropped", dm.dmem_req_valid, 0);
        for (int i = 0; i < sdelay; i++) begin
            if (fmode == 1 && i == 0) is_flush = 1;
            cyc();
            is_flush = 0;
        end
        dm.dmem_resp_valid = 1; dm.dmem_resp_rdata = rdata;
        if (fmode == 2) is_flush = 1;
        cyc();
        dm.dmem_resp_valid = 0; is_flush = 0;
        chk("ld_wb_en", wb_en, wb);
        chk("ld_busy_done", lsu_busy, 0);
    endtask

    task automatic do_misaligned(input bit store, input logic [63:0] addr, input int size);
        in_valid = 1; in_load = !store; in_store = store; in_size = size[1:0]; in_reg_dest = 5'd4;
        in_data = store ? 64'h1111 : addr; in_mem_addr = store ? addr : 64'h0;
        mis_expected++;
        cyc();
        in_valid = 0; in_load = 0; in_store = 0;
        chk("mis_pulse", misaligned, 1);
        chk("mis_no_req", dm.dmem_req_valid, 0);
        chk("mis_busy", lsu_busy, 0);
        chk("mis_wb_en", wb_en, 0);
        cyc();
        chk("mis_pulse_end", misaligned, 0);
    endtask

    initial begin
        reset = 0; in_valid = 0; in_store = 0; in_load = 0; in_unsigned = 0; is_flush = 0;
        in_data = 0; in_mem_addr = 0; in_size = 0; in_reg_dest = 0; in_pc = 0;
        dm.dmem_req_ready = 0; dm.dmem_resp_valid = 0; dm.dmem_resp_rdata = 0;

        // Scoreboard: every cycle, check writebacks, requests and pulses.
        fork
            forever begin
                @(negedge clk);
                if (reset) begin
                    if (wb_en) begin
                        if (exp_q.size() == 0) begin
                            chk("wb_unexpected", wb_en, 0);
                        end else begin
                            wb_t e;
                            e = exp_q.pop_front();
                            chk("wb_reg", 64'(wb_reg), 64'(e.r));
                            chk("wb_data", wb_data, e.d);
                            chk("wb_pc", 64'(wb_pc), 64'(e.pc));
                        end
                    end
                    if (dm.dmem_req_valid) begin
                        req_cycles++;
                        obs_addr = dm.dmem_req_addr; obs_wdata = dm.dmem_req_wdata;
                        obs_wstrb = dm.dmem_req_wstrb;
                        if (!req_exp_valid) begin
                            chk("req_unexpected", dm.dmem_req_valid, 0);
                        end else begin
                            chk("req_we", dm.dmem_req_we, req_e_we);
                            chk("req_addr", dm.dmem_req_addr, req_e_addr);
                            chk("req_wdata", dm.dmem_req_wdata, req_e_wdata);
                            chk("req_wstrb", dm.dmem_req_wstrb, req_e_wstrb);
                        end
                    end
                    if (misaligned) begin
                        mis_seen++;
                        chk("mis_expected", (mis_seen <= mis_expected), 1);
                    end
                end
            end
        join_none

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", lsu_busy, 0);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_req_valid", dm.dmem_req_valid, 0);
        chk("rst_misaligned", misaligned, 0);
        reset = 1;
        cyc();

        // ALU pass-through.
        do_alu(64'h1234, 5'd5, 32'h100);
        chk("alu_lit_reg", 64'(wb_reg), 64'd5);
        chk("alu_lit_data", wb_data, 64'h1234);
        do_alu(64'h9999, 5'd0, 32'h104);
        cyc();
        chk("alu_dest0_quiet", wb_en, 0);

        // Back-to-back ALU ops.
        do_alu(64'hA1, 5'd1, 32'h200);
        do_alu(64'hB2, 5'd2, 32'h204);
        do_alu(64'hC3, 5'd31, 32'h208);
        chk("b2b_lit_data", wb_data, 64'hC3);
        cyc();
        chk("b2b_wb_end", wb_en, 0);

        // Flush in IDLE suppresses acceptance.
        in_valid = 1; in_reg_dest = 5'd7; in_data = 64'h77; is_flush = 1;
        cyc();
        in_valid = 0; is_flush = 0;
        chk("flush_idle_wb", wb_en, 0);

        // SW with ready held low 3 cycles.
        do_store(64'hDEADBEEF, 64'h1004, 2, 3);
        chk("sw_req_cycles", req_cycles, 4);
        chk("sw_lit_addr", obs_addr, 64'h1000);
        chk("sw_lit_wstrb", 64'(obs_wstrb), 64'hF0);
        chk("sw_lit_wdata", obs_wdata, 64'hDEADBEEF_00000000);
        do_store(64'hCAFE, 64'h2006, 1, 0);
        chk("sh_req_cycles", req_cycles, 1);
        do_store(64'h0123_4567_89AB_CDEF, 64'h2008, 3, 1);
        do_store(64'h5A, 64'h3001, 0, 0);

        // Loads.
        do_load(64'h2003, 0, 0, 5'd6, 32'h300, 0, 2, 64'h00000000_80000000, 0);
        chk("lb_lit_data", wb_data, 64'hFFFFFFFF_FFFFFF80);
        do_load(64'h2003, 0, 1, 5'd6, 32'h304, 0, 2, 64'h00000000_80000000, 0);
        chk("lbu_lit_data", wb_data, 64'h80);
        do_load(64'h4006, 1, 0, 5'd8, 32'h308, 1, 0, 64'h8123_0000_0000_0000, 0);
        chk("lh_lit_data", wb_data, 64'hFFFFFFFF_FFFF8123);
        do_load(64'h4004, 2, 1, 5'd9, 32'h30C, 0, 0, 64'hF000_000F_1234_5678, 0);
        chk("lwu_lit_data", wb_data, 64'h00000000_F000000F);
        do_load(64'h4008, 3, 0, 5'd10, 32'h310, 2, 1, 64'h8765_4321_0FED_CBA9, 0);
        do_load(64'h4010, 2, 0, 5'd0, 32'h314, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);

        // Misaligned accesses.
        do_misaligned(0, 64'h3004, 3);
        do_misaligned(1, 64'h1001, 1);
        chk("mis_count", mis_seen, mis_expected);

        // Flushes during an outstanding load, then immediate acceptance.
        do_load(64'h5000, 3, 0, 5'd11, 32'h400, 0, 2, 64'h1111, 1);
        do_alu(64'h4242, 5'd12, 32'h404);
        chk("post_flush_lit", wb_data, 64'h4242);
        do_load(64'h5008, 3, 0, 5'd13, 32'h408, 0, 1, 64'h2222, 2);
        do_load(64'h5010, 2, 0, 5'd14, 32'h40C, 2, 0, 64'h3333, 3);
        do_alu(64'h55, 5'd15, 32'h410);

        // Reset during REQ.
        in_valid = 1; in_load = 1; in_data = 64'h6000; in_size = 2'd3; in_reg_dest = 5'd9;
        req_e_we = 0; req_e_addr = 64'h6000; req_e_wdata = 0; req_e_wstrb = 0; req_exp_valid = 1;
        cyc();
        in_valid = 0; in_load = 0;
        chk("rreq_valid", dm.dmem_req_valid, 1);
        #2 reset = 0;
        #1;
        chk("rreq_valid_cleared", dm.dmem_req_valid, 0);
        chk("rreq_busy_cleared", lsu_busy, 0);
        chk("rreq_addr_cleared", dm.dmem_req_addr, 0);
        chk("rreq_wb_data_cleared", wb_data, 0);
        req_exp_valid = 0;
        cyc();
        cyc();
        reset = 1;
        dm.dmem_resp_valid = 1; dm.dmem_resp_rdata = 64'hBAD;
        cyc();
        dm.dmem_resp_valid = 0;
        chk("late_resp_wb", wb_en, 0);
        chk("late_resp_busy", lsu_busy, 0);
        cyc();
        chk("late_resp_wb2", wb_en, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
